// File: rtl/axi_mem_txn_limiter.sv
// AXI4 outstanding-transaction limiter between the core memory master and the address mapper.
// It caps outstanding read/write bursts, holds W beats until their AW has been accepted,
// and offers a drain/quiesce handshake. All channels are otherwise combinational pass-through.
//
// Ports:
//   uncoreclk, uncorersts         : clock, synchronous active-high reset
//   s_axi_*                       : slave port toward the core (AW, W, B, AR, R)
//   m_axi_*                       : master port toward the address mapper (mirror of s_axi_*)
//   drain_req                     : level request to stop issuing new AR/AW
//   drain_done                    : draining and nothing outstanding
//   rd_outstanding/wr_outstanding : outstanding read/write burst counts
//   rd_stall_cycles/wr_stall_cycles (AXI_MEM_TXN_LIMITER_STATS_EN only) : saturating counts of
//                                   cycles a valid AR/AW was held back by the limit
//
// Optional feature macro: AXI_MEM_TXN_LIMITER_STATS_EN
module axi_mem_txn_limiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 1,
  parameter int unsigned MAX_RD = 8,
  parameter int unsigned MAX_WR = 8
) (
  input  logic                uncoreclk,
  input  logic                uncorersts,
  // AW core side
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  // W core side
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  // B core side
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  // AR core side
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  // R core side
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  // AW mapper side
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  // W mapper side
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  // B mapper side
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  // AR mapper side
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  // R mapper side
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  // Control and status
  input  logic                drain_req,
  output logic                drain_done,
`ifdef AXI_MEM_TXN_LIMITER_STATS_EN
  output logic [31:0]         rd_stall_cycles,
  output logic [31:0]         wr_stall_cycles,
`endif
  output logic [7:0]          rd_outstanding,
  output logic [7:0]          wr_outstanding
);

  typedef enum logic [1:0] {StRun, StDrain, StIdle} state_e;

  state_e     state_q;
  logic       drain_done_q;
  logic [7:0] rd_out_q, rd_out_d;
  logic [7:0] wr_out_q, wr_out_d;
  logic [7:0] w_pend_q, w_pend_d;

  logic ar_ok, aw_ok, w_ok, rd_room, wr_room;
  logic ar_fire, r_last_fire, aw_fire, b_fire, w_last_fire;

  // Decrement at zero is a protocol violation; hold zero rather than wrap.
  function automatic logic [7:0] upd_cnt(logic [7:0] cnt, logic inc, logic dec);
    logic [7:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + 8'd1;
    end else if (dec && !inc && cnt != 8'd0) begin
      res = cnt - 8'd1;
    end
    return res;
  endfunction

  // Gates depend only on registered state, so no valid->ready combinational loop.
  assign rd_room = rd_out_q < 8'(MAX_RD);
  assign wr_room = (wr_out_q < 8'(MAX_WR)) && (w_pend_q < 8'(MAX_WR));
  assign ar_ok   = rd_room && (state_q == StRun);
  assign aw_ok   = wr_room && (state_q == StRun);
  assign w_ok    = w_pend_q != 8'd0;

  assign m_axi_arvalid = s_axi_arvalid & ar_ok;
  assign s_axi_arready = m_axi_arready & ar_ok;
  assign m_axi_awvalid = s_axi_awvalid & aw_ok;
  assign s_axi_awready = m_axi_awready & aw_ok;
  assign m_axi_wvalid  = s_axi_wvalid & w_ok;
  assign s_axi_wready  = m_axi_wready & w_ok;

  // Payloads and response channels pass straight through.
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awlock  = s_axi_awlock;
  assign m_axi_awcache = s_axi_awcache;
  assign m_axi_awprot  = s_axi_awprot;
  assign m_axi_awqos   = s_axi_awqos;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign s_axi_bvalid  = m_axi_bvalid;
  assign m_axi_bready  = s_axi_bready;
  assign s_axi_bid     = m_axi_bid;
  assign s_axi_bresp   = m_axi_bresp;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_arlock  = s_axi_arlock;
  assign m_axi_arcache = s_axi_arcache;
  assign m_axi_arprot  = s_axi_arprot;
  assign m_axi_arqos   = s_axi_arqos;
  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rlast;

  assign ar_fire     = m_axi_arvalid & m_axi_arready;
  assign r_last_fire = m_axi_rvalid & s_axi_rready & m_axi_rlast;
  assign aw_fire     = m_axi_awvalid & m_axi_awready;
  assign b_fire      = m_axi_bvalid & s_axi_bready;
  assign w_last_fire = m_axi_wvalid & m_axi_wready & s_axi_wlast;

  always_comb begin
    rd_out_d = upd_cnt(rd_out_q, ar_fire, r_last_fire);
    wr_out_d = upd_cnt(wr_out_q, aw_fire, b_fire);
    w_pend_d = upd_cnt(w_pend_q, aw_fire, w_last_fire);
  end

  always_ff @(posedge uncoreclk) begin
    if (uncorersts) begin
      rd_out_q <= 8'd0;
      wr_out_q <= 8'd0;
      w_pend_q <= 8'd0;
    end else begin
      rd_out_q <= rd_out_d;
      wr_out_q <= wr_out_d;
      w_pend_q <= w_pend_d;
    end
  end

  // Idle is judged on next-state counts so drain_done rises the cycle after the last completion.
  always_ff @(posedge uncoreclk) begin
    if (uncorersts) begin
      state_q      <= StRun;
      drain_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (drain_req) state_q <= StDrain;
        end
        StDrain: begin
          if (!drain_req) begin
            state_q <= StRun;
          end else if (rd_out_d == 8'd0 && wr_out_d == 8'd0 && w_pend_d == 8'd0) begin
            state_q      <= StIdle;
            drain_done_q <= 1'b1;
          end
        end
        StIdle: begin
          if (!drain_req) begin
            state_q      <= StRun;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StRun;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign drain_done     = drain_done_q;
  assign rd_outstanding = rd_out_q;
  assign wr_outstanding = wr_out_q;

`ifdef AXI_MEM_TXN_LIMITER_STATS_EN
  logic [31:0] rd_stall_q, wr_stall_q;
  logic        rd_limit_block, wr_limit_block;

  // Only limit stalls count; cycles blocked by drain are excluded.
  assign rd_limit_block = s_axi_arvalid && (state_q == StRun) && !rd_room;
  assign wr_limit_block = s_axi_awvalid && (state_q == StRun) && !wr_room;

  always_ff @(posedge uncoreclk) begin
    if (uncorersts) begin
      rd_stall_q <= 32'd0;
      wr_stall_q <= 32'd0;
    end else begin
      if (rd_limit_block && rd_stall_q != 32'hFFFF_FFFF) rd_stall_q <= rd_stall_q + 32'd1;
      if (wr_limit_block && wr_stall_q != 32'hFFFF_FFFF) wr_stall_q <= wr_stall_q + 32'd1;
    end
  end

  assign rd_stall_cycles = rd_stall_q;
  assign wr_stall_cycles = wr_stall_q;
`endif

endmodule
